// File: rtl/simt_core_param.sv
// simt_core_param: N-thread round-robin SIMT core with host-loadable instruction and data memories.
// Optional macro PERF_COUNTERS_EN adds saturating cycle_count/instr_count outputs.
module simt_core_param #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REG_COUNT   = 16,
  parameter int unsigned IMEM_DEPTH  = 16,
  parameter int unsigned DMEM_DEPTH  = 16,
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int unsigned PC_W  = $clog2(IMEM_DEPTH),
  localparam int unsigned DA_W  = $clog2(DMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   prog_we,
  input  logic [PC_W-1:0]        prog_addr,
  input  logic [15:0]            prog_wdata,
  input  logic                   host_we,
  input  logic [DA_W-1:0]        host_addr,
  input  logic [DATA_WIDTH-1:0]  host_wdata,
  output logic [DATA_WIDTH-1:0]  host_rdata,
  output logic [NUM_THREADS-1:0] active_mask
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            instr_count
`endif
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JLT  = 4'h8;
  localparam logic [3:0] OP_LDR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state;
  logic [PC_W-1:0]        pc    [NUM_THREADS];
  logic [DATA_WIDTH-1:0]  regs  [NUM_THREADS][REG_COUNT];
  logic [15:0]            imem  [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0]  dmem  [DMEM_DEPTH];
  logic [NUM_THREADS-1:0] flag;
  logic [TID_W-1:0]       rr_ptr;

  logic                   run;
  logic                   launch;
  logic                   issue;
  logic                   any_active;
  logic                   hit_hi;
  logic [TID_W-1:0]       lo_any;
  logic [TID_W-1:0]       lo_hi;
  logic [TID_W-1:0]       issue_tid;
  logic [TID_W-1:0]       ptr_next;
  logic [NUM_THREADS-1:0] mask_after;

  logic [15:0]            instr;
  logic [3:0]             op;
  logic [3:0]             rd;
  logic [3:0]             rs1;
  logic [3:0]             rs2;
  logic [7:0]             imm;
  logic [DATA_WIDTH-1:0]  imm_sx;
  logic [DATA_WIDTH-1:0]  rs1_val;
  logic [DATA_WIDTH-1:0]  rs2_val;
  logic [DATA_WIDTH-1:0]  rd_val;
  logic [DA_W-1:0]        mem_addr;
  logic [PC_W-1:0]        cur_pc;
  logic [PC_W-1:0]        next_pc;
  logic                   rf_we;
  logic [DATA_WIDTH-1:0]  rf_wdata;
  logic                   st_en;
  logic                   cmp_we;
  logic                   cmp_val;
  logic                   is_halt;

  assign run    = (state == S_RUN);
  assign launch = start && !run;
  assign issue  = run && any_active;

  // Lowest active thread at or after the pointer, else lowest active overall (wrap).
  always_comb begin
    lo_any     = '0;
    lo_hi      = '0;
    hit_hi     = 1'b0;
    any_active = 1'b0;
    for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
      if (active_mask[i]) begin
        lo_any     = TID_W'(i);
        any_active = 1'b1;
        if (TID_W'(i) >= rr_ptr) begin
          lo_hi  = TID_W'(i);
          hit_hi = 1'b1;
        end
      end
    end
    issue_tid  = hit_hi ? lo_hi : lo_any;
    ptr_next   = (issue_tid == TID_W'(NUM_THREADS - 1)) ? '0 : issue_tid + TID_W'(1);
    mask_after = active_mask & ~(NUM_THREADS'(1) << issue_tid);
  end

  // Decode and execute the issued thread's instruction.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    st_en    = 1'b0;
    cmp_we   = 1'b0;
    cmp_val  = 1'b0;
    is_halt  = 1'b0;
    cur_pc   = pc[issue_tid];
    instr    = imem[cur_pc];
    op       = instr[15:12];
    rd       = instr[11:8];
    rs1      = instr[7:4];
    rs2      = instr[3:0];
    imm      = instr[7:0];
    imm_sx   = DATA_WIDTH'($signed(imm));
    rs1_val  = regs[issue_tid][rs1];
    rs2_val  = regs[issue_tid][rs2];
    rd_val   = regs[issue_tid][rd];
    mem_addr = DA_W'(rs1_val + imm_sx);
    next_pc  = cur_pc + PC_W'(1);
    case (op)
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
      OP_SUB:  begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
      OP_MUL:  begin rf_we = 1'b1; rf_wdata = rs1_val * rs2_val; end
      OP_CMP:  begin cmp_we = 1'b1; cmp_val = (rs1_val < rs2_val); end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = rd_val + imm_sx; end
      OP_SUBI: begin rf_we = 1'b1; rf_wdata = rd_val - imm_sx; end
      OP_JMP:  next_pc = imm[PC_W-1:0];
      OP_JLT:  if (flag[issue_tid]) next_pc = imm[PC_W-1:0];
      OP_LDR:  begin rf_we = 1'b1; rf_wdata = dmem[mem_addr]; end
      OP_STR:  st_en = 1'b1;
      OP_HALT: begin is_halt = 1'b1; next_pc = cur_pc; end
      default: ;
    endcase
  end

  // Control FSM, per-thread PCs, flags, round-robin pointer and host read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      active_mask <= '0;
      flag        <= '0;
      rr_ptr      <= '0;
      host_rdata  <= '0;
      for (int t = 0; t < int'(NUM_THREADS); t++) pc[t] <= '0;
    end else begin
      host_rdata <= dmem[host_addr];
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            active_mask <= '1;
            flag        <= '0;
            rr_ptr      <= '0;
            for (int t = 0; t < int'(NUM_THREADS); t++) pc[t] <= '0;
          end
        end
        S_RUN: begin
          if (any_active) begin
            pc[issue_tid] <= next_pc;
            rr_ptr        <= ptr_next;
            if (cmp_we) flag[issue_tid] <= cmp_val;
            if (is_halt) begin
              active_mask[issue_tid] <= 1'b0;
              if (mask_after == '0) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file: cleared on launch with R15 holding the thread id.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (launch) begin
        for (int t = 0; t < int'(NUM_THREADS); t++)
          for (int r = 0; r < int'(REG_COUNT); r++)
            regs[t][r] <= (r == 15) ? DATA_WIDTH'(t) : '0;
      end else if (issue && rf_we) begin
        regs[issue_tid][rd] <= rf_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !run && prog_we) imem[prog_addr] <= prog_wdata;
  end

  // Host writes only outside RUN; a reset edge suppresses thread stores.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (issue && st_en) dmem[mem_addr] <= rd_val;
      else if (!run && host_we) dmem[host_addr] <= host_wdata;
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (launch) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (run) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
      if (issue && instr_count != '1) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simt_core_param.sv
// Bench for simt_core_param: ISA-level reference model with per-cycle compare plus directed programs.
module tb_simt_core_param;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset, start, busy, done, prog_we, host_we;
  logic [3:0]  prog_addr, host_addr;
  logic [15:0] prog_wdata, host_wdata, host_rdata;
  logic [3:0]  active_mask;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  simt_core_param dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .active_mask(active_mask)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: instruction-level interpreter of the thread set.
  int          m_state = 0;   // 0 idle, 1 run, 2 done
  bit          m_valid = 1'b0;
  logic [15:0] m_imem [16];
  logic [15:0] m_dmem [16];
  bit          m_dk   [16];
  logic [15:0] m_regs [NT][16];
  logic [3:0]  m_pc   [NT];
  logic [NT-1:0] m_act, m_flag;
  int          m_ptr;
  logic [15:0] m_rdata;
  bit          m_rk;
  logic [31:0] m_cyc, m_ins;
  int          m_order[$];

  function automatic int m_pick();
    int c;
    for (int k = 0; k < NT; k++) begin
      c = (m_ptr + k) % NT;
      if (m_act[c]) return c;
    end
    return -1;
  endfunction

  task automatic m_launch();
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < 16; r++) m_regs[t][r] = (r == 15) ? 16'(t) : 16'h0;
      m_pc[t] = 4'h0;
    end
    m_act = '1; m_flag = '0; m_ptr = 0; m_cyc = 0; m_ins = 0;
    m_order.delete();
    m_state = 1;
  endtask

  task automatic m_exec();
    int t;
    logic [15:0] ins, rv1, rv2, sx, a16;
    logic [3:0] op, rd, rs1, rs2, npc;
    logic [7:0] imm;
    t = m_pick();
    if (t < 0) return;
    m_order.push_back(t);
    ins = m_imem[m_pc[t]];
    op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0]; imm = ins[7:0];
    sx  = {{8{imm[7]}}, imm};
    rv1 = m_regs[t][rs1];
    rv2 = m_regs[t][rs2];
    a16 = rv1 + sx;
    npc = m_pc[t] + 4'd1;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    if (m_ins != 32'hFFFF_FFFF) m_ins = m_ins + 1;
    case (op)
      4'h1: m_regs[t][rd] = rv1 + rv2;
      4'h2: m_regs[t][rd] = rv1 - rv2;
      4'h3: m_regs[t][rd] = rv1 * rv2;
      4'h4: m_flag[t] = (rv1 < rv2);
      4'h5: m_regs[t][rd] = m_regs[t][rd] + sx;
      4'h6: m_regs[t][rd] = m_regs[t][rd] - sx;
      4'h7: npc = imm[3:0];
      4'h8: if (m_flag[t]) npc = imm[3:0];
      4'h9: m_regs[t][rd] = m_dmem[a16[3:0]];
      4'hA: begin m_dmem[a16[3:0]] = m_regs[t][rd]; m_dk[a16[3:0]] = 1'b1; end
      4'hF: begin m_act[t] = 1'b0; npc = m_pc[t]; end
      default: ;
    endcase
    m_pc[t] = npc;
    m_ptr = (t + 1) % NT;
    if (m_act == '0) m_state = 2;
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b1; m_state = 0; m_act = '0; m_flag = '0; m_ptr = 0;
      m_rdata = 16'h0; m_rk = 1'b1; m_cyc = 0; m_ins = 0;
      for (int t = 0; t < NT; t++) m_pc[t] = 4'h0;
    end else begin
      m_rk = m_dk[host_addr];
      m_rdata = m_dmem[host_addr];
      if (m_state != 1) begin
        if (prog_we) m_imem[prog_addr] = prog_wdata;
        if (host_we) begin m_dmem[host_addr] = host_wdata; m_dk[host_addr] = 1'b1; end
        if (start) m_launch();
      end else begin
        m_exec();
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_state == 1));
      check("done", 32'(done), 32'(m_state == 2));
      check("active_mask", 32'(active_mask), 32'(m_act));
      if (m_rk) check("host_rdata", 32'(host_rdata), 32'(m_rdata));
      if (m_state == 1) check("issue_tid", 32'(dut.issue_tid), 32'(m_pick()));
`ifdef PERF_COUNTERS_EN
      check("cycle_count", cycle_count, m_cyc);
      check("instr_count", instr_count, m_ins);
`endif
    end
  end

  logic [15:0] pbuf [16];

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) pbuf[i] = 16'hF000;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = pbuf[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    host_we = 1'b1; host_addr = 4'(a); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic mem_expect(input string name, input int a, input logic [15:0] exp);
    host_addr = 4'(a);
    @(negedge clk);
    check(name, 32'(host_rdata), 32'(exp));
  endtask

  // Launch, optionally poke prog/host/start during RUN, and count RUN cycles.
  task automatic run_prog(input bit inject, output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      if (inject && cyc == 2) begin
        prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 16'hF000;
        host_we = 1'b1; host_addr = 4'd14; host_wdata = 16'hBEEF;
        start = 1'b1;
      end else begin
        prog_we = 1'b0; host_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    prog_we = 1'b0; host_we = 1'b0; start = 1'b0;
    if (cyc >= 2000) check("run_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last2, cnt2;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; host_we = 1'b0;
    prog_addr = 4'h0; prog_wdata = 16'h0; host_addr = 4'h0; host_wdata = 16'h0;
    repeat (5) @(negedge clk);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_mask", 32'(active_mask), 32'd0);

    for (int i = 0; i < 16; i++) host_write(i, 16'h0100 + 16'(i));
    host_write(5, 16'h1234);

    // Per-thread arithmetic and store to M[tid].
    clear_prog();
    pbuf[0] = 16'h5105; pbuf[1] = 16'h121F; pbuf[2] = 16'hA2F0; pbuf[3] = 16'hF000;
    load_prog();
    run_prog(1'b0, cyc);
    check("p1_cycles", 32'(cyc), 32'd16);
    check("p1_done", 32'(done), 32'd1);
    check("p1_mask", 32'(active_mask), 32'd0);
    for (int i = 0; i < 4; i++) mem_expect("p1_mem", i, 16'(5 + i));
    check("model_p1_m3", 32'(m_dmem[3]), 32'd8);

    // Counted loop; all threads end with R1=3.
    clear_prog();
    pbuf[0] = 16'h5303; pbuf[1] = 16'h5101; pbuf[2] = 16'h4013;
    pbuf[3] = 16'h8001; pbuf[4] = 16'hA1F0;
    load_prog();
    run_prog(1'b0, cyc);
    check("loop_cycles", 32'(cyc), 32'd48);
    for (int i = 0; i < 4; i++) mem_expect("loop_r1", i, 16'd3);
    for (int k = 0; k < 8; k++) check("rr_order", 32'(m_order[k]), 32'(k % 4));

    // Thread 2 halts early, others loop four times.
    clear_prog();
    pbuf[0] = 16'h5202; pbuf[1] = 16'h5304; pbuf[2] = 16'h24F2; pbuf[3] = 16'h4004;
    pbuf[4] = 16'h8006; pbuf[5] = 16'hF000; pbuf[6] = 16'h5101; pbuf[7] = 16'h4013;
    pbuf[8] = 16'h8006; pbuf[9] = 16'hA1F0;
    load_prog();
    run_prog(1'b0, cyc);
    check("skip_cycles", 32'(cyc), 32'd63);
    last2 = -1; cnt2 = 0;
    foreach (m_order[k]) if (m_order[k] == 2) begin last2 = k; cnt2++; end
    check("t2_last_issue", 32'(last2), 32'd22);
    check("t2_issue_count", 32'(cnt2), 32'd6);
    mem_expect("skip_m0", 0, 16'd4);
    mem_expect("skip_m2", 2, 16'd3);
    mem_expect("skip_m3", 3, 16'd4);

    // Register-indexed loads/stores with address wrap.
    host_write(0, 16'h00AA);
    host_write(15, 16'h0BBB);
    clear_prog();
    pbuf[0] = 16'h9405; pbuf[1] = 16'hA4F8; pbuf[2] = 16'h95FF; pbuf[3] = 16'hA5FC;
    load_prog();
    run_prog(1'b0, cyc);
    check("ldr_cycles", 32'(cyc), 32'd20);
    for (int i = 8; i < 12; i++) mem_expect("ldr_copy", i, 16'h1234);
    mem_expect("wrap_t1_m0", 13, 16'h00AA);
    mem_expect("wrap_t0_m15", 12, 16'h0BBB);

    // Reset on the edge of thread 3's store: that store must be lost.
    for (int i = 4; i < 8; i++) host_write(i, 16'hAAAA);
    clear_prog();
    pbuf[0] = 16'hAFF4;
    load_prog();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mask", 32'(active_mask), 32'd0);
    for (int i = 0; i < 3; i++) mem_expect("abort_store", 4 + i, 16'(i));
    mem_expect("abort_dropped", 7, 16'hAAAA);

    // prog_we/host_we/start during RUN are dropped.
    host_write(14, 16'h0E0E);
    clear_prog();
    pbuf[0] = 16'h5105; pbuf[1] = 16'h121F; pbuf[2] = 16'hA2F0;
    load_prog();
    run_prog(1'b1, cyc);
    check("inject_cycles", 32'(cyc), 32'd16);
    for (int i = 0; i < 4; i++) mem_expect("inject_mem", i, 16'(5 + i));
    mem_expect("inject_host_drop", 14, 16'h0E0E);

    // Relaunch from DONE clears registers.
    for (int i = 0; i < 4; i++) host_write(i, 16'h0000);
    check("relaunch_from_done", 32'(done), 32'd1);
    run_prog(1'b0, cyc);
    check("relaunch_cycles", 32'(cyc), 32'd16);
    for (int i = 0; i < 4; i++) mem_expect("relaunch_mem", i, 16'(5 + i));
`ifdef PERF_COUNTERS_EN
    check("perf_cycles_final", cycle_count, 32'd16);
    check("perf_instr_final", instr_count, 32'd16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
